// File: rtl/d_cache_pkg.sv
// Shared types and constants for the direct-mapped, write-through data cache.
package d_cache_pkg;

    localparam int INDEX_BITS_DEF  = 6;
    localparam int OFFSET_BITS_DEF = 4;

    localparam logic [2:0]  KSEG1     = 3'b101;
    localparam logic [31:0] PHYS_MASK = 32'h1FFF_FFFF;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [3:0] {
        IDLE,
        REFILL_REQ,
        REFILL_WAIT,
        UC_REQ,
        UC_WAIT,
        RD_DONE,
        WR_REQ,
        WR_WAIT,
        WR_DONE
    } state_t;

    function automatic int tag_bits(input int ib, input int ob);
        return 32 - ib - ob;
    endfunction

    function automatic int words(input int ob);
        return 2 ** (ob - 2);
    endfunction

endpackage

// File: rtl/dcache_storage.sv
// Valid/tag/data arrays: combinational read, byte-strobed word write,
// whole-line valid+tag fill and asynchronous valid clear.
module dcache_storage
    import d_cache_pkg::*;
#(
    parameter int INDEX_BITS  = INDEX_BITS_DEF,
    parameter int OFFSET_BITS = OFFSET_BITS_DEF,
    localparam int TAG_BITS   = tag_bits(INDEX_BITS, OFFSET_BITS),
    localparam int WORD_BITS  = OFFSET_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] index,
    input  logic [WORD_BITS-1:0]  rd_word,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [WORD_BITS-1:0]  wr_word,
    input  logic [3:0]            wr_strb,
    input  logic [31:0]           wr_data,
    input  logic                  fill_en,
    input  logic [TAG_BITS-1:0]   fill_tag
);

    localparam int LINES = 2 ** INDEX_BITS;
    localparam int WORDS = words(OFFSET_BITS);

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tags [LINES];
    logic [31:0]         data [LINES][WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[index] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until valid is set.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[index] <= fill_tag;
        end
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_strb[b]) begin
                data[index][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_valid = valid[index];
    assign rd_tag   = tags[index];
    assign rd_data  = data[index][rd_word];

endmodule

// File: rtl/d_cache.sv
// Data cache for the M-stage memory port: direct-mapped, write-through,
// no-write-allocate, kseg1 bypass, single-outstanding downstream bus.
module d_cache
    import d_cache_pkg::*;
#(
    parameter int INDEX_BITS  = INDEX_BITS_DEF,
    parameter int OFFSET_BITS = OFFSET_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int TAG_BITS  = tag_bits(INDEX_BITS, OFFSET_BITS);
    localparam int WORD_BITS = OFFSET_BITS - 2;
    localparam int LINE_LSB  = INDEX_BITS + OFFSET_BITS;

    state_t state, state_n;
    logic [WORD_BITS-1:0] cnt;
    logic [31:0]          uc_buf;

    logic [31:0]           paddr;
    logic                  uncached;
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] index;
    logic [WORD_BITS-1:0]  word_sel;
    logic                  unused_lsb;

    logic                 rd_valid;
    logic [TAG_BITS-1:0]  rd_tag;
    logic [31:0]          rd_data;
    logic                 hit;
    logic                 wr_en;
    logic [WORD_BITS-1:0] wr_word;
    logic [3:0]           wr_strb;
    logic [31:0]          wr_data;
    logic                 fill_en;
    logic [1:0]           wr_size;
    logic [1:0]           wr_lsb;

    assign paddr      = cpu_addr & PHYS_MASK;
    assign uncached   = (cpu_addr[31:29] == KSEG1);
    assign tag        = paddr[31:LINE_LSB];
    assign index      = paddr[LINE_LSB-1:OFFSET_BITS];
    assign word_sel   = paddr[OFFSET_BITS-1:2];
    assign unused_lsb = ^paddr[1:0];

    assign hit = rd_valid & (rd_tag == tag) & ~uncached;

    dcache_storage #(
        .INDEX_BITS (INDEX_BITS),
        .OFFSET_BITS(OFFSET_BITS)
    ) u_storage (
        .clk     (clk),
        .rst     (rst),
        .index   (index),
        .rd_word (word_sel),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_word (wr_word),
        .wr_strb (wr_strb),
        .wr_data (wr_data),
        .fill_en (fill_en),
        .fill_tag(tag)
    );

    // Write size follows the strobe count; the address LSBs follow the
    // lowest enabled lane.
    always_comb begin
        case ($countones(cpu_wen))
            1:       wr_size = SIZE_BYTE;
            2:       wr_size = SIZE_HALF;
            default: wr_size = SIZE_WORD;
        endcase
        if (cpu_wen[0])      wr_lsb = 2'd0;
        else if (cpu_wen[1]) wr_lsb = 2'd1;
        else if (cpu_wen[2]) wr_lsb = 2'd2;
        else if (cpu_wen[3]) wr_lsb = 2'd3;
        else                 wr_lsb = 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            uc_buf <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                cnt <= '0;
            end else if (state == REFILL_WAIT && mem_data_ok) begin
                cnt <= cnt + 1'b1;
            end
            if (state == UC_WAIT && mem_data_ok) begin
                uc_buf <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (cpu_en) begin
                    if (|cpu_wen)     state_n = WR_REQ;
                    else if (uncached) state_n = UC_REQ;
                    else if (!hit)     state_n = REFILL_REQ;
                end
            end
            REFILL_REQ:  if (mem_addr_ok) state_n = REFILL_WAIT;
            REFILL_WAIT: if (mem_data_ok) state_n = (&cnt) ? IDLE : REFILL_REQ;
            UC_REQ:      if (mem_addr_ok) state_n = UC_WAIT;
            UC_WAIT:     if (mem_data_ok) state_n = RD_DONE;
            RD_DONE:     state_n = IDLE;
            WR_REQ:      if (mem_addr_ok) state_n = WR_WAIT;
            WR_WAIT:     if (mem_data_ok) state_n = WR_DONE;
            WR_DONE:     state_n = IDLE;
            default:     state_n = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = SIZE_BYTE;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        unique case (state)
            REFILL_REQ: begin
                mem_req  = 1'b1;
                mem_size = SIZE_WORD;
                mem_addr = {paddr[31:OFFSET_BITS], cnt, 2'b00};
            end
            UC_REQ: begin
                mem_req  = 1'b1;
                mem_size = SIZE_WORD;
                mem_addr = {paddr[31:2], 2'b00};
            end
            WR_REQ: begin
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_size  = wr_size;
                mem_addr  = {paddr[31:2], wr_lsb};
                mem_wdata = cpu_wdata;
                mem_wstrb = cpu_wen;
            end
            default: ;
        endcase

        // Refill words and write hits share the byte-strobed write port.
        if (state == REFILL_WAIT) begin
            wr_en   = mem_data_ok;
            wr_word = cnt;
            wr_strb = 4'hF;
            wr_data = mem_rdata;
        end else begin
            wr_en   = (state == IDLE) & cpu_en & (|cpu_wen) & hit;
            wr_word = word_sel;
            wr_strb = cpu_wen;
            wr_data = cpu_wdata;
        end
        fill_en = (state == REFILL_WAIT) & mem_data_ok & (&cnt);

        cpu_stall = ~rst & cpu_en
                  & ~(state == IDLE & ~(|cpu_wen) & hit)
                  & ~(state == RD_DONE | state == WR_DONE);
        cpu_rdata = (state == RD_DONE) ? uc_buf
                  : (rd_valid ? rd_data : '0);
    end

endmodule

// File: tb/tb_d_cache.sv
// Directed bench for d_cache: vector table plus backpressure and
// mid-refill reset sequences against a single-outstanding bus model.
module tb_d_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    d_cache dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_en     (cpu_en),
        .cpu_wen    (cpu_wen),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_size   (mem_size),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok),
        .mem_rdata  (mem_rdata)
    );

    logic [31:0] mem [logic [31:0]];
    int          hold_cnt = 0;
    int          req_cnt  = 0;
    int          rsp_cnt  = 0;
    logic        pend     = 1'b0;
    logic [31:0] pend_data;
    logic [31:0] last_addr;
    logic [1:0]  last_size;
    logic [3:0]  last_strb;
    logic        last_wr;

    int passed = 0;
    int total  = 0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], 16'hC0DE};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            passed++;
    endtask

    // Bus model: grants one request at a time, answers one cycle later.
    initial begin
        logic [31:0] wa;
        logic [31:0] w;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
        forever begin
            @(negedge clk);
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else if (pend) begin
                mem_data_ok = 1'b1;
                mem_rdata   = pend_data;
                pend        = 1'b0;
                rsp_cnt++;
            end else if (mem_req) begin
                if (hold_cnt > 0) begin
                    hold_cnt--;
                end else begin
                    mem_addr_ok = 1'b1;
                    pend        = 1'b1;
                    req_cnt++;
                    last_addr = mem_addr;
                    last_size = mem_size;
                    last_strb = mem_wstrb;
                    last_wr   = mem_wr;
                    wa = {mem_addr[31:2], 2'b00};
                    if (mem_wr) begin
                        w = mem_read(wa);
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                        mem[wa]   = w;
                        pend_data = '0;
                    end else begin
                        pend_data = mem_read(wa);
                    end
                end
            end
        end
    end

    task automatic wait_done(output logic [31:0] rd, output int cyc,
                             output logic post);
        #1;
        cyc = 0;
        while (cpu_stall && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 100) begin
            total++;
            $display("FAIL timeout: stall still %b after %0d cycles", cpu_stall, cyc);
        end
        rd = cpu_rdata;
        @(posedge clk);
        #1;
        post = cpu_stall;
        @(negedge clk);
        cpu_en  = 1'b0;
        cpu_wen = '0;
    endtask

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          reqs;
        logic [31:0] last_a;
        logic [1:0]  size;
        int          cycles;
        logic        post;
    } vec_t;

    vec_t v[11];

    initial begin
        logic [31:0] rd;
        int          cyc;
        logic        post;
        int          base;

        mem[32'h0000_0100] = 32'h11;
        mem[32'h0000_0104] = 32'h22;
        mem[32'h0000_0108] = 32'h33;
        mem[32'h0000_010C] = 32'h44;
        mem[32'h1FAF_8000] = 32'hDEAD_BEEF;

        v[0]  = '{4'h0, 32'h8000_0104, 32'h0,         32'h22,         4, 32'h0000_010C, 2'd2, 9, 1'b0};
        v[1]  = '{4'h0, 32'h8000_010C, 32'h0,         32'h44,         0, 32'h0,         2'd0, 0, 1'b0};
        v[2]  = '{4'h8, 32'h8000_0107, 32'hAB00_0000, 32'h0,          1, 32'h0000_0107, 2'd0, 3, 1'b1};
        v[3]  = '{4'h0, 32'h8000_0104, 32'h0,         32'hAB00_0022,  0, 32'h0,         2'd0, 0, 1'b0};
        v[4]  = '{4'hC, 32'h8000_0106, 32'hCDEF_0000, 32'h0,          1, 32'h0000_0106, 2'd1, 3, 1'b1};
        v[5]  = '{4'h0, 32'h8000_0104, 32'h0,         32'hCDEF_0022,  0, 32'h0,         2'd0, 0, 1'b0};
        v[6]  = '{4'hF, 32'h8000_2000, 32'h1234_5678, 32'h0,          1, 32'h0000_2000, 2'd2, 3, 1'b1};
        v[7]  = '{4'h0, 32'h8000_2000, 32'h0,         32'h1234_5678,  4, 32'h0000_200C, 2'd2, 9, 1'b0};
        v[8]  = '{4'h0, 32'hBFAF_8002, 32'h0,         32'hDEAD_BEEF,  1, 32'h1FAF_8000, 2'd2, 3, 1'b1};
        v[9]  = '{4'h0, 32'hBFAF_8002, 32'h0,         32'hDEAD_BEEF,  1, 32'h1FAF_8000, 2'd2, 3, 1'b1};
        v[10] = '{4'h0, 32'h8000_2008, 32'h0,         32'h2008_C0DE,  0, 32'h0,         2'd0, 0, 1'b0};

        rst       = 1'b1;
        cpu_en    = 1'b1;
        cpu_wen   = '0;
        cpu_addr  = 32'h8000_0104;
        cpu_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset mem_req", {31'd0, mem_req}, 32'd0);
        check("reset stall", {31'd0, cpu_stall}, 32'd0);
        check("reset rdata", cpu_rdata, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_ctl", {22'd0, mem_wr, mem_size, mem_wstrb}, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        cpu_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            base      = req_cnt;
            cpu_en    = 1'b1;
            cpu_wen   = v[i].wen;
            cpu_addr  = v[i].addr;
            cpu_wdata = v[i].wdata;
            wait_done(rd, cyc, post);
            if (v[i].wen == 4'h0)
                check($sformatf("v%0d rdata", i), rd, v[i].rdata);
            check($sformatf("v%0d reqs", i), req_cnt - base, v[i].reqs);
            check($sformatf("v%0d cycles", i), cyc, v[i].cycles);
            check($sformatf("v%0d post-stall", i), {31'd0, post}, {31'd0, v[i].post});
            if (v[i].reqs > 0) begin
                check($sformatf("v%0d last addr", i), last_addr, v[i].last_a);
                check($sformatf("v%0d size", i), {30'd0, last_size}, {30'd0, v[i].size});
                check($sformatf("v%0d wr", i), {31'd0, last_wr}, {31'd0, v[i].wen != 4'h0});
                check($sformatf("v%0d strb", i), {28'd0, last_strb}, {28'd0, v[i].wen});
            end
        end

        // Backpressure on an uncached read: request must hold steady.
        hold_cnt  = 5;
        base      = req_cnt;
        cpu_en    = 1'b1;
        cpu_wen   = '0;
        cpu_addr  = 32'hA000_0040;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp%0d req", i), {31'd0, mem_req}, 32'd1);
            check($sformatf("bp%0d addr", i), mem_addr, 32'h0000_0040);
            check($sformatf("bp%0d stall", i), {31'd0, cpu_stall}, 32'd1);
        end
        wait_done(rd, cyc, post);
        check("bp rdata", rd, 32'h0040_C0DE);
        check("bp reqs", req_cnt - base, 1);

        // Reset after two refill words: line must stay invalid.
        base     = rsp_cnt;
        cpu_en   = 1'b1;
        cpu_wen  = '0;
        cpu_addr = 32'h8000_0300;
        for (int i = 0; i < 100 && rsp_cnt - base < 2; i++) @(posedge clk);
        check("mid-refill words", rsp_cnt - base, 2);
        #1 rst = 1'b1;
        #1;
        check("rst mid req", {31'd0, mem_req}, 32'd0);
        check("rst mid stall", {31'd0, cpu_stall}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        base = req_cnt;
        wait_done(rd, cyc, post);
        check("re-read reqs", req_cnt - base, 4);
        check("re-read rdata", rd, 32'h0300_C0DE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
